// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INST        = 32'h0000_0013;
  localparam int          PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs a single-outstanding IMEM handshake
// and feeds IF/ID, with a one-entry skid for acks that land during a stall.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            NextPCSrc,
  input  logic [XLEN-1:0] Adress,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
  logic [31:0]     skid_inst_reg, skid_inst_next;
  logic [XLEN-1:0] skid_pc_reg, skid_pc_next;
  logic            if_valid_reg, if_valid_next;
  logic [31:0]     if_inst_reg, if_inst_next;
  logic [XLEN-1:0] if_pc_reg, if_pc_next;

  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] pc_inc;
  logic            out_can_load;

  assign redirect_target = Adress & ALIGN_MASK;
  assign pc_inc          = pc_reg + XLEN'(PC_STEP);
  assign out_can_load    = !if_valid_reg || !stall;

  // The request address is always the PC: it only advances on an ack, so it
  // stays stable for the whole outstanding request, including in KILL.
  assign imem_req  = (state_reg == REQ) || (state_reg == KILL);
  assign imem_addr = pc_reg;
  assign if_valid  = if_valid_reg;
  assign if_inst   = if_inst_reg;
  assign if_pc     = if_pc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      pend_pc_reg   <= RESET_PC;
      skid_inst_reg <= NOP_INST;
      skid_pc_reg   <= RESET_PC;
      if_valid_reg  <= 1'b0;
      if_inst_reg   <= NOP_INST;
      if_pc_reg     <= RESET_PC;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      pend_pc_reg   <= pend_pc_next;
      skid_inst_reg <= skid_inst_next;
      skid_pc_reg   <= skid_pc_next;
      if_valid_reg  <= if_valid_next;
      if_inst_reg   <= if_inst_next;
      if_pc_reg     <= if_pc_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    pend_pc_next   = pend_pc_reg;
    skid_inst_next = skid_inst_reg;
    skid_pc_next   = skid_pc_reg;
    if_valid_next  = if_valid_reg;
    if_inst_next   = if_inst_reg;
    if_pc_next     = if_pc_reg;

    // A consumed instruction retires unless something below refills the slot.
    if (out_can_load) begin
      if_valid_next = 1'b0;
    end

    unique case (state_reg)
      IDLE: begin
        state_next = REQ;
      end

      REQ: begin
        if (NextPCSrc) begin
          if_valid_next = 1'b0;
          if (imem_ack) begin
            pc_next = redirect_target;
          end else begin
            pend_pc_next = redirect_target;
            state_next   = KILL;
          end
        end else if (imem_ack) begin
          pc_next = pc_inc;
          if (out_can_load) begin
            if_valid_next = 1'b1;
            if_inst_next  = imem_rdata;
            if_pc_next    = pc_reg;
          end else begin
            skid_inst_next = imem_rdata;
            skid_pc_next   = pc_reg;
            state_next     = HOLD;
          end
        end
      end

      HOLD: begin
        if (NextPCSrc) begin
          if_valid_next = 1'b0;
          pc_next       = redirect_target;
          state_next    = REQ;
        end else if (!stall) begin
          if_valid_next = 1'b1;
          if_inst_next  = skid_inst_reg;
          if_pc_next    = skid_pc_reg;
          state_next    = REQ;
        end
      end

      KILL: begin
        if (NextPCSrc) begin
          if_valid_next = 1'b0;
          pend_pc_next  = redirect_target;
        end
        // The stale response is swallowed; a redirect arriving with it wins.
        if (imem_ack) begin
          pc_next    = NextPCSrc ? redirect_target : pend_pc_reg;
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: one linear stimulus sequence with
// hand-computed expectations checked by immediate assertions.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        NextPCSrc;
  logic [31:0] Adress;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_ctrl #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .PC_STEP (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .NextPCSrc (NextPCSrc),
    .Adress    (Adress),
    .stall     (stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid  (if_valid),
    .if_inst   (if_inst),
    .if_pc     (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".req"},   32'(imem_req), 32'h0);
    chk({tag, ".addr"},  imem_addr,     32'h0);
    chk({tag, ".valid"}, 32'(if_valid), 32'h0);
    chk({tag, ".inst"},  if_inst,       32'h0000_0013);
    chk({tag, ".pc"},    if_pc,         32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    NextPCSrc  = 1'b0;
    Adress     = 32'h0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    // Reset
    tick();
    tick();
    chk_reset_values("rst");

    // 1: zero-wait streaming
    rst_n = 1'b1;
    tick();
    chk("t1.req",  32'(imem_req), 32'h1);
    chk("t1.addr0", imem_addr, 32'h0);
    chk("t1.valid0", 32'(if_valid), 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
    tick();
    chk("t1.valid", 32'(if_valid), 32'h1);
    chk("t1.inst0", if_inst, 32'hA000_0000);
    chk("t1.pc0",   if_pc,   32'h0);
    chk("t1.addr4", imem_addr, 32'h4);
    imem_rdata = 32'hA000_0004;
    tick();
    chk("t1.pc4",   if_pc,   32'h4);
    chk("t1.addr8", imem_addr, 32'h8);
    imem_rdata = 32'hA000_0008;
    tick();
    chk("t1.pc8",   if_pc,   32'h8);
    chk("t1.addrC", imem_addr, 32'hC);

    // 2: ack delayed 3 cycles
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2.req",   32'(imem_req), 32'h1);
      chk("t2.addr",  imem_addr,     32'hC);
      chk("t2.valid", 32'(if_valid), 32'h0);
    end
    imem_ack = 1'b1; imem_rdata = 32'hA000_000C;
    tick();
    chk("t2.valid1", 32'(if_valid), 32'h1);
    chk("t2.inst",   if_inst, 32'hA000_000C);
    chk("t2.pc",     if_pc,   32'hC);
    chk("t2.addr10", imem_addr, 32'h10);
    imem_ack = 1'b0;
    tick();
    chk("t2.pulse", 32'(if_valid), 32'h0);

    // 3: ack during stall parks in the skid register
    imem_ack = 1'b1; imem_rdata = 32'hB000_0010;
    tick();
    chk("t3.pc10", if_pc, 32'h10);
    stall = 1'b1; imem_rdata = 32'hB000_0014;
    tick();
    chk("t3.req0",  32'(imem_req), 32'h0);
    chk("t3.hinst", if_inst, 32'hB000_0010);
    chk("t3.hvalid", 32'(if_valid), 32'h1);
    imem_ack = 1'b0;
    tick();
    chk("t3.req0b", 32'(imem_req), 32'h0);
    chk("t3.hpc",   if_pc, 32'h10);
    stall = 1'b0;
    tick();
    chk("t3.inst",  if_inst, 32'hB000_0014);
    chk("t3.pc",    if_pc,   32'h14);
    chk("t3.req",   32'(imem_req), 32'h1);
    chk("t3.addr",  imem_addr, 32'h18);

    // 4: redirect while outstanding -> KILL; latest target wins, aligned
    NextPCSrc = 1'b1; Adress = 32'h40;
    tick();
    chk("t4.req",   32'(imem_req), 32'h1);
    chk("t4.addr",  imem_addr, 32'h18);
    chk("t4.valid", 32'(if_valid), 32'h0);
    Adress = 32'h7F;
    tick();
    chk("t4.addr2", imem_addr, 32'h18);
    NextPCSrc = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t4.valid2", 32'(if_valid), 32'h0);
    chk("t4.newaddr", imem_addr, 32'h7C);
    chk("t4.req2",  32'(imem_req), 32'h1);

    // 5: redirect with simultaneous ack and stall
    imem_rdata = 32'hC000_007C;
    tick();
    chk("t5.pre",  if_pc, 32'h7C);
    stall = 1'b1; NextPCSrc = 1'b1; Adress = 32'h8; imem_rdata = 32'hBAD0_0000;
    tick();
    chk("t5.valid", 32'(if_valid), 32'h0);
    chk("t5.addr",  imem_addr, 32'h8);
    chk("t5.req",   32'(imem_req), 32'h1);
    NextPCSrc = 1'b0; imem_ack = 1'b0; stall = 1'b0;
    tick();
    chk("t5.addr2", imem_addr, 32'h8);
    chk("t5.inst",  if_inst, 32'hC000_007C);

    // Redirect out of HOLD
    imem_ack = 1'b1; imem_rdata = 32'hD000_0008;
    tick();
    stall = 1'b1; imem_rdata = 32'hD000_000C;
    tick();
    chk("th.req0", 32'(imem_req), 32'h0);
    imem_ack = 1'b0; NextPCSrc = 1'b1; Adress = 32'h20;
    tick();
    chk("th.req",   32'(imem_req), 32'h1);
    chk("th.addr",  imem_addr, 32'h20);
    chk("th.valid", 32'(if_valid), 32'h0);
    stall = 1'b0;

    // 6: PC wrap, then reset in the middle of KILL
    Adress = 32'hFFFF_FFFC; imem_ack = 1'b1;
    tick();
    chk("t6.addrtop", imem_addr, 32'hFFFF_FFFC);
    NextPCSrc = 1'b0; imem_rdata = 32'hE000_0000;
    tick();
    chk("t6.wrap",  imem_addr, 32'h0);
    chk("t6.pc",    if_pc, 32'hFFFF_FFFC);
    imem_ack = 1'b0; NextPCSrc = 1'b1; Adress = 32'h100;
    tick();
    chk("t6.kill",  imem_addr, 32'h0);
    NextPCSrc = 1'b0; rst_n = 1'b0;
    tick();
    chk_reset_values("t6.rst");
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    chk("t6.ignack", 32'(if_valid), 32'h0);
    chk("t6.req",    32'(imem_req), 32'h1);
    imem_rdata = 32'hF000_0000;
    tick();
    chk("t6.inst",  if_inst, 32'hF000_0000);
    chk("t6.valid", 32'(if_valid), 32'h1);
    imem_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
